// File: rtl/linebuf_window_ctrl.sv
// Line-buffer sequencer for the 5x5 window filters: gates the shift enable, tracks the
// window centre coordinate and border flags, and flushes zero padding at end of frame.
module linebuf_window_ctrl #(
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720,
    parameter int XW    = 11,
    parameter int YW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    output logic          sr_clken,
    output logic          sr_pad,
    output logic          win_valid,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic [3:0]    win_border,
    output logic          frame_done,
    output logic          err_sof
);

    localparam int KW = XW + 2;
    localparam logic [KW-1:0] LAT     = KW'(2 * IMG_W + 2);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_RIGHT = XW'(IMG_W - 3);
    localparam logic [YW-1:0] Y_BOT   = YW'(IMG_H - 3);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] fcnt;
    logic [XW-1:0] ix;
    logic [XW-1:0] cx;
    logic [YW-1:0] iy;
    logic [YW-1:0] cy;
    logic          done_pend;
    logic          accept;
    logic          sof_acc;
    logic          emit;
    logic          last_pix;

    always_comb begin
        in_ready = (state != FLUSH);
        sr_pad   = (state == FLUSH);
        case (state)
            IDLE:    sr_clken = in_valid & in_sof;
            FLUSH:   sr_clken = 1'b1;
            default: sr_clken = in_valid;
        endcase
        accept   = in_valid & in_ready;
        sof_acc  = accept & in_sof;
        // A restarting SOF in RUN is a FILL shift of the new frame, so it never emits.
        emit     = ((state == RUN) & accept & ~in_sof) | (state == FLUSH);
        last_pix = (ix == X_LAST) && (iy == Y_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            fcnt       <= '0;
            ix         <= '0;
            iy         <= '0;
            cx         <= '0;
            cy         <= '0;
            done_pend  <= 1'b0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            win_border <= '0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            err_sof    <= 1'b0;
            done_pend  <= 1'b0;
            frame_done <= done_pend;
            win_valid  <= emit;

            if (emit) begin
                win_x      <= cx;
                win_y      <= cy;
                win_border <= {cy > Y_BOT, cy < YW'(2), cx > X_RIGHT, cx < XW'(2)};
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (sof_acc) begin
                        state <= FILL;
                        k     <= KW'(1);
                        ix    <= XW'(1);
                        iy    <= '0;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                FILL, RUN: begin
                    if (sof_acc) begin
                        err_sof <= 1'b1;
                        state   <= FILL;
                        k       <= KW'(1);
                        ix      <= XW'(1);
                        iy      <= '0;
                        cx      <= '0;
                        cy      <= '0;
                    end else if (accept) begin
                        if (ix == X_LAST) begin
                            ix <= '0;
                            iy <= iy + YW'(1);
                        end else begin
                            ix <= ix + XW'(1);
                        end
                        if (state == FILL) begin
                            k <= k + KW'(1);
                            if (k + KW'(1) == LAT) begin
                                state <= RUN;
                            end
                        end else if (last_pix) begin
                            state <= FLUSH;
                            fcnt  <= '0;
                        end
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + KW'(1);
                    if (fcnt == LAT - KW'(1)) begin
                        state     <= IDLE;
                        done_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Directed bench for linebuf_window_ctrl on an 8x6 image (LAT = 18 shifts).
module tb_linebuf_window_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;
    logic       sr_clken;
    logic       sr_pad;
    logic       win_valid;
    logic [3:0] win_x;
    logic [2:0] win_y;
    logic [3:0] win_border;
    logic       frame_done;
    logic       err_sof;

    int vectors     = 0;
    int miscompares = 0;

    int mx, my, win_cnt, first_shift, shifts, flush_wins, done_cnt;
    int last_x, last_y, last_cyc, done_cyc, cyc_no;
    logic pre_clken, pre_ready, pre_pad;
    logic [3:0] exp_b;

    linebuf_window_ctrl #(
        .IMG_W(8),
        .IMG_H(6),
        .XW   (4),
        .YW   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .sr_clken  (sr_clken),
        .sr_pad    (sr_pad),
        .win_valid (win_valid),
        .win_x     (win_x),
        .win_y     (win_y),
        .win_border(win_border),
        .frame_done(frame_done),
        .err_sof   (err_sof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic new_frame();
        mx = 0; my = 0; win_cnt = 0; first_shift = -1; shifts = 0;
        flush_wins = 0; done_cnt = 0; last_x = -1; last_y = -1;
        last_cyc = 0; done_cyc = 0;
    endtask

    // Called at posedge+1; applies inputs for one clock and checks any window after the edge.
    task automatic cyc(input logic v, input logic s);
        in_valid = v;
        in_sof   = s;
        #1;
        pre_clken = sr_clken;
        pre_ready = in_ready;
        pre_pad   = sr_pad;
        if (sr_clken) shifts++;
        @(posedge clk);
        #1;
        cyc_no++;
        if (win_valid) begin
            exp_b = {my > 3, my < 2, mx > 5, mx < 2};
            chk("win_x", 32'(win_x), 32'(mx));
            chk("win_y", 32'(win_y), 32'(my));
            chk("win_border", 32'(win_border), 32'(exp_b));
            if (mx == 3 && my == 3) chk("border_3_3", 32'(win_border), 32'd0);
            if (first_shift < 0) first_shift = shifts;
            if (pre_pad && !pre_ready) flush_wins++;
            last_x = mx; last_y = my; last_cyc = cyc_no;
            win_cnt++;
            mx++;
            if (mx == 8) begin mx = 0; my++; end
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc_no;
        end
    endtask

    task automatic run_frame(input bit gap, input logic exp_err);
        new_frame();
        for (int unsigned p = 0; p < 48; p++) begin
            if (gap) begin
                cyc(1'b0, 1'b0);
                chk("gap_clken", 32'(pre_clken), 32'd0);
            end
            cyc(1'b1, p == 0);
            chk("pix_clken", 32'(pre_clken), 32'd1);
            if (p == 0) chk("err_sof", 32'(err_sof), 32'(exp_err));
        end
        for (int unsigned c = 0; c < 30 && done_cnt == 0; c++) cyc(1'b0, 1'b0);
        chk("win_count", 32'(win_cnt), 32'd48);
        chk("first_win_shift", 32'(first_shift), 32'd19);
        chk("flush_wins", 32'(flush_wins), 32'd18);
        chk("input_wins", 32'(win_cnt - flush_wins), 32'd30);
        chk("last_x", 32'(last_x), 32'd7);
        chk("last_y", 32'(last_y), 32'd5);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_delay", 32'(done_cyc - last_cyc), 32'd1);
        cyc(1'b0, 1'b0);
        chk("done_pulse", 32'(frame_done), 32'd0);
    endtask

    initial begin
        cyc_no   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        new_frame();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_win_valid", 32'(win_valid), 32'd0);
        chk("rst_win_xy", {win_x, 1'b0, win_y}, 32'd0);
        chk("rst_border", 32'(win_border), 32'd0);
        chk("rst_done_err", {frame_done, err_sof}, 32'd0);
        chk("rst_pad", 32'(sr_pad), 32'd0);
        rst = 1'b0;

        // Back-to-back frame, then the same frame with alternating valid gaps.
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);

        // Non-SOF pixels while idle are dropped.
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            chk("idle_ready", 32'(pre_ready), 32'd1);
            chk("idle_clken", 32'(pre_clken), 32'd0);
            chk("idle_win", 32'(win_valid), 32'd0);
        end

        // SOF after 20 pixels restarts the frame.
        new_frame();
        for (int unsigned p = 0; p < 20; p++) cyc(1'b1, p == 0);
        chk("pre_restart_wins", 32'(win_cnt), 32'd2);
        run_frame(1'b0, 1'b1);

        // Asynchronous reset during FLUSH.
        new_frame();
        for (int unsigned p = 0; p < 48; p++) cyc(1'b1, p == 0);
        for (int unsigned c = 0; c < 5; c++) cyc(1'b0, 1'b0);
        chk("in_flush_pad", 32'(sr_pad), 32'd1);
        chk("in_flush_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_pad", 32'(sr_pad), 32'd0);
        chk("arst_clken", 32'(sr_clken), 32'd0);
        chk("arst_win_valid", 32'(win_valid), 32'd0);
        chk("arst_win_xy", {win_x, 1'b0, win_y}, 32'd0);
        chk("arst_border", 32'(win_border), 32'd0);
        chk("arst_done_err", {frame_done, err_sof}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
